// File: rtl/dispatch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_pkg / dispatch_unit_if
//  Brief    : Shared op types and the decode-to-dispatch bus with
//             decoder-side (master) and dispatch-side (slave) views.
//  Revision : 1.0  initial release
// ============================================================================

package dispatch_pkg;

    localparam int c_FU_W = 3;

    // Ids 4..7 are encodable so an out-of-range unit can reach the queue.
    typedef enum logic [c_FU_W-1:0] {
        FU_ALU  = 3'd0,
        FU_MUL  = 3'd1,
        FU_LSU  = 3'd2,
        FU_BRU  = 3'd3,
        FU_RSV4 = 3'd4,
        FU_RSV5 = 3'd5,
        FU_RSV6 = 3'd6,
        FU_RSV7 = 3'd7
    } e_functional_unit;

    typedef struct packed {
        logic [31:0] insn;
        logic [7:0]  enc;
    } op_t;

endpackage

interface dispatch_unit_if #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 6
);
    import dispatch_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    e_functional_unit      in_rs_id;
    op_t                   in_op;
    logic                  flush;
    logic [NUM_UNITS-1:0]  disp_valid;
    logic [NUM_UNITS-1:0]  disp_ready;
    op_t                   disp_op;
    logic [TAG_W-1:0]      disp_tag;
    logic                  illegal_insn;
    logic [TAG_W-1:0]      illegal_tag;

    modport master (
        output in_valid, in_rs_id, in_op, flush, disp_ready,
        input  in_ready, disp_valid, disp_op, disp_tag, illegal_insn, illegal_tag
    );

    modport slave (
        input  in_valid, in_rs_id, in_op, flush, disp_ready,
        output in_ready, disp_valid, disp_op, disp_tag, illegal_insn, illegal_tag
    );

endinterface

`default_nettype wire

// File: rtl/dispatch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_unit
//  Brief    : In-order dispatch queue that tags decoded ops and routes the
//             head to its reservation station. Optional feature macro:
//             DISPATCH_ILLEGAL_TRAP_EN (drop and report out-of-range unit ids).
//  Revision : 1.0  initial release
// ============================================================================

module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dispatch_unit_if.slave  bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_FU_W-1:0]   r_rs_id [DEPTH];
    op_t                 r_op    [DEPTH];
    logic [TAG_W-1:0]    r_tag   [DEPTH];

    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [TAG_W-1:0]    r_next_tag;

    logic                w_full;
    logic                w_empty;
    logic                w_take;
    logic                w_illegal;
    logic                w_enq;
    logic                w_pop;
    logic [c_FU_W-1:0]   w_in_id;
    logic [c_FU_W-1:0]   w_head_id;
    logic [NUM_UNITS-1:0] w_disp_valid;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_in_id   = bus.in_rs_id;
    assign w_head_id = r_rs_id[r_rd_ptr];

    // A flushed push is discarded outright and does not consume a tag.
    assign w_take = bus.in_valid && !w_full && !bus.flush;

`ifdef DISPATCH_ILLEGAL_TRAP_EN
    assign w_illegal = (32'(w_in_id) >= 32'(NUM_UNITS));
`else
    assign w_illegal = 1'b0;
`endif

    assign w_enq = w_take && !w_illegal;

    generate
        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_route
            assign w_disp_valid[u] = !w_empty && (w_head_id == c_FU_W'(u));
        end
    endgenerate

    assign w_pop = (|(w_disp_valid & bus.disp_ready)) && !bus.flush;

    assign bus.in_ready   = !w_full;
    assign bus.disp_valid = w_disp_valid;
    assign bus.disp_op    = r_op[r_rd_ptr];
    assign bus.disp_tag   = r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_next_tag <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rs_id[i] <= '0;
                r_op[i]    <= '0;
                r_tag[i]   <= '0;
            end
        end else begin
            if (w_take) begin
                r_next_tag <= r_next_tag + TAG_W'(1);
            end
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) begin
                    r_rs_id[r_wr_ptr] <= w_in_id;
                    r_op[r_wr_ptr]    <= bus.in_op;
                    r_tag[r_wr_ptr]   <= r_next_tag;
                    r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_pop);
            end
        end
    end

`ifdef DISPATCH_ILLEGAL_TRAP_EN
    logic             r_illegal_insn;
    logic [TAG_W-1:0] r_illegal_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_insn <= 1'b0;
            r_illegal_tag  <= '0;
        end else begin
            r_illegal_insn <= w_take && w_illegal;
            r_illegal_tag  <= (w_take && w_illegal) ? r_next_tag : '0;
        end
    end

    assign bus.illegal_insn = r_illegal_insn;
    assign bus.illegal_tag  = r_illegal_tag;
`else
    assign bus.illegal_insn = 1'b0;
    assign bus.illegal_tag  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dispatch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dispatch_unit
//  Brief    : Directed self-checking bench for dispatch_unit.
//  Revision : 1.0  initial release
// ============================================================================

module tb_dispatch_unit;
    import dispatch_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_tag;

    dispatch_unit_if #(.NUM_UNITS(4), .TAG_W(6)) bus ();

    dispatch_unit #(.DEPTH(4), .NUM_UNITS(4), .TAG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int id, input logic [31:0] insn);
        bus.in_valid = v;
        bus.in_rs_id = e_functional_unit'(3'(id));
        bus.in_op    = '{insn: insn, enc: 8'h00};
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.disp_ready = 4'h0;
        drive(1'b0, 0, 32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset state
        do_reset();
        chk("rst_in_ready",   64'(bus.in_ready), 64'd1);
        chk("rst_disp_valid", 64'(bus.disp_valid), 64'h0);
        chk("rst_illegal",    64'(bus.illegal_insn), 64'd0);
        chk("rst_ill_tag",    64'(bus.illegal_tag), 64'd0);
        chk("rst_disp_tag",   64'(bus.disp_tag), 64'd0);
        chk("rst_disp_op",    64'(bus.disp_op), 64'd0);

        // One-cycle latency
        bus.disp_ready = 4'hF;
        drive(1'b1, 2, 32'h00A0_0093);
        step();
        drive(1'b0, 0, 32'h0);
        chk("lat_valid", 64'(bus.disp_valid), 64'b0100);
        chk("lat_tag",   64'(bus.disp_tag), 64'd0);
        chk("lat_insn",  64'(bus.disp_op.insn), 64'h00A0_0093);
        step();
        chk("lat_empty", 64'(bus.disp_valid), 64'h0);

        // Fill and back-pressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 32'h100 + 32'(i));
            step();
            chk("fill_ready", 64'(bus.in_ready), (i < 3) ? 64'd1 : 64'd0);
        end
        drive(1'b1, 1, 32'h104);
        step();
        chk("full_hold_ready", 64'(bus.in_ready), 64'd0);
        chk("full_head_tag",   64'(bus.disp_tag), 64'd0);
        bus.disp_ready = 4'hF;
        step();
        chk("rel_tag1",  64'(bus.disp_tag), 64'd1);
        chk("rel_ready", 64'(bus.in_ready), 64'd1);
        step();
        drive(1'b0, 0, 32'h0);
        chk("rel_tag2", 64'(bus.disp_tag), 64'd2);
        step();
        chk("rel_tag3", 64'(bus.disp_tag), 64'd3);
        step();
        chk("rel_tag4",   64'(bus.disp_tag), 64'd4);
        chk("rel_valid4", 64'(bus.disp_valid), 64'b0010);
        chk("rel_insn4",  64'(bus.disp_op.insn), 64'h104);
        step();
        chk("rel_empty", 64'(bus.disp_valid), 64'h0);

        // Head-of-line blocking: units 1, 0, 3 with unit 1 stalled
        bus.disp_ready = 4'b1101;
        drive(1'b1, 1, 32'h201);
        step();
        chk("hol_push1", 64'(bus.disp_valid), 64'b0010);
        drive(1'b1, 0, 32'h200);
        step();
        chk("hol_push0", 64'(bus.disp_valid), 64'b0010);
        drive(1'b1, 3, 32'h203);
        step();
        drive(1'b0, 0, 32'h0);
        chk("hol_push3", 64'(bus.disp_valid), 64'b0010);
        step();
        chk("hol_stall_valid", 64'(bus.disp_valid), 64'b0010);
        chk("hol_stall_tag",   64'(bus.disp_tag), 64'd5);
        bus.disp_ready = 4'hF;
        step();
        chk("hol_pop0_valid", 64'(bus.disp_valid), 64'b0001);
        chk("hol_pop0_tag",   64'(bus.disp_tag), 64'd6);
        step();
        chk("hol_pop3_valid", 64'(bus.disp_valid), 64'b1000);
        chk("hol_pop3_tag",   64'(bus.disp_tag), 64'd7);
        step();
        chk("hol_empty", 64'(bus.disp_valid), 64'h0);

        // Streaming with simultaneous push/pop and tag wrap
        exp_tag = 8;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, i % 4, 32'(i));
            step();
            chk("stream_valid", 64'(bus.disp_valid), 64'(1 << (i % 4)));
            chk("stream_tag",   64'(bus.disp_tag), 64'(exp_tag % 64));
            chk("stream_ready", 64'(bus.in_ready), 64'd1);
            exp_tag++;
        end
        drive(1'b0, 0, 32'h0);
        step();
        chk("stream_drain", 64'(bus.disp_valid), 64'h0);

        // Flush with three entries plus a same-cycle push
        exp_tag = exp_tag % 64;
        bus.disp_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 32'h300 + 32'(i));
            step();
        end
        chk("pre_flush_tag", 64'(bus.disp_tag), 64'(exp_tag));
        drive(1'b1, 3, 32'h3FF);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 0, 32'h0);
        chk("flush_empty", 64'(bus.disp_valid), 64'h0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 2, 32'h310);
        step();
        drive(1'b0, 0, 32'h0);
        chk("post_flush_valid", 64'(bus.disp_valid), 64'b0100);
        chk("post_flush_tag",   64'(bus.disp_tag), 64'((exp_tag + 3) % 64));
        chk("post_flush_insn",  64'(bus.disp_op.insn), 64'h310);
        bus.disp_ready = 4'hF;
        step();
        chk("post_flush_drain", 64'(bus.disp_valid), 64'h0);

        // Out-of-range unit id carrying tag 7
        do_reset();
        bus.disp_ready = 4'hF;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 0, 32'h400 + 32'(i));
            step();
        end
        drive(1'b1, 4, 32'h4FF);
        step();
`ifdef DISPATCH_ILLEGAL_TRAP_EN
        drive(1'b1, 1, 32'h401);
        chk("ill_pulse", 64'(bus.illegal_insn), 64'd1);
        chk("ill_tag",   64'(bus.illegal_tag), 64'd7);
        chk("ill_valid", 64'(bus.disp_valid), 64'h0);
        step();
        drive(1'b0, 0, 32'h0);
        chk("ill_pulse_end", 64'(bus.illegal_insn), 64'd0);
        chk("ill_tag_end",   64'(bus.illegal_tag), 64'd0);
        chk("ill_next_tag",  64'(bus.disp_tag), 64'd8);
        chk("ill_next_vld",  64'(bus.disp_valid), 64'b0010);
`else
        drive(1'b1, 1, 32'h401);
        chk("oor_valid",   64'(bus.disp_valid), 64'h0);
        chk("oor_tag",     64'(bus.disp_tag), 64'd7);
        chk("oor_illegal", 64'(bus.illegal_insn), 64'd0);
        chk("oor_ill_tag", 64'(bus.illegal_tag), 64'd0);
        step();
        drive(1'b0, 0, 32'h0);
        chk("oor_blocked", 64'(bus.disp_valid), 64'h0);
        step();
        chk("oor_stalled", 64'(bus.disp_valid), 64'h0);
        chk("oor_head",    64'(bus.disp_tag), 64'd7);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b1, 1, 32'h402);
        step();
        drive(1'b0, 0, 32'h0);
        chk("oor_recover_vld", 64'(bus.disp_valid), 64'b0010);
        chk("oor_recover_tag", 64'(bus.disp_tag), 64'd9);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
